// File: rtl/i3c_bus_harness_timed.sv
// Cycle-timed I3C bus resolver: per-device delay lines, wired-AND SDA/SCL with
// open-drain rise modelling, push-pull shortcut and SDA contention counting.
module i3c_bus_harness_timed #(
  parameter int NumDevices = 3,
  parameter int MaxDelay   = 15,
  parameter int DelayW     = $clog2(MaxDelay + 1),
  parameter int RiseW      = 8,
  parameter int CntW       = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NumDevices-1:0]        sda_i,
  input  logic [NumDevices-1:0]        scl_i,
  input  logic [NumDevices-1:0]        sel_od_pp_i,
  input  logic [NumDevices*DelayW-1:0] dly_cfg_i,
  input  logic [RiseW-1:0]             rise_cfg_i,
  input  logic                         clear_i,
  output logic                         sda_o,
  output logic                         scl_o,
  output logic                         contention_o,
  output logic [CntW-1:0]              contention_cnt_o
);

  localparam int Depth   = MaxDelay + 1;
  localparam int LineSda = 0;
  localparam int LineScl = 1;

  typedef enum logic [1:0] {
    ST_HIGH,
    ST_LOW,
    ST_RISING
  } line_state_e;

  logic [Depth-1:0]      r_sda_dl [NumDevices];
  logic [Depth-1:0]      r_scl_dl [NumDevices];
  logic [NumDevices-1:0] w_sda_del;
  logic [NumDevices-1:0] w_scl_del;
  logic [1:0]            w_any_low;
  logic [1:0]            w_pp_high;
  logic                  w_contention;
  line_state_e           r_state    [2];
  logic [RiseW-1:0]      r_rise_cnt [2];
  logic [RiseW-1:0]      r_rise_tgt [2];
  logic                  r_contention;
  logic [CntW-1:0]       r_cnt;

  function automatic logic [DelayW-1:0] sat_tap(input logic [DelayW-1:0] d);
    return (d > DelayW'(MaxDelay)) ? DelayW'(MaxDelay) : d;
  endfunction

  // NOTE: the delay taps are plain flops rather than a RAM, so they can and must
  // be reset to the released level; otherwise stale lows would replay after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumDevices; k++) begin
        r_sda_dl[k] <= '1;
        r_scl_dl[k] <= '1;
      end
    end else begin
      for (int k = 0; k < NumDevices; k++) begin
        r_sda_dl[k] <= (r_sda_dl[k] << 1) | Depth'(sda_i[k]);
        r_scl_dl[k] <= (r_scl_dl[k] << 1) | Depth'(scl_i[k]);
      end
    end
  end

  // NOTE: defaults first so every path assigns every bit and no latch is inferred.
  always_comb begin
    w_sda_del = '1;
    w_scl_del = '1;
    for (int k = 0; k < NumDevices; k++) begin
      w_sda_del[k] = r_sda_dl[k][sat_tap(dly_cfg_i[k*DelayW +: DelayW])];
      w_scl_del[k] = r_scl_dl[k][sat_tap(dly_cfg_i[k*DelayW +: DelayW])];
    end
  end

  assign w_any_low[LineSda] = ~&w_sda_del;
  assign w_any_low[LineScl] = ~&w_scl_del;
  assign w_pp_high[LineSda] = |(w_sda_del & sel_od_pp_i);
  assign w_pp_high[LineScl] = |(w_scl_del & sel_od_pp_i);
  assign w_contention       = w_pp_high[LineSda] & w_any_low[LineSda];

  // NOTE: all state updates use non-blocking assignments so both lines and the
  // counter see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int l = 0; l < 2; l++) begin
        r_state[l]    <= ST_HIGH;
        r_rise_cnt[l] <= '0;
        r_rise_tgt[l] <= '0;
      end
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (w_any_low[l]) begin
          r_state[l]    <= ST_LOW;
          r_rise_cnt[l] <= '0;
        end else begin
          case (r_state[l])
            ST_LOW: begin
              if (w_pp_high[l] || rise_cfg_i == '0) begin
                r_state[l] <= ST_HIGH;
              end else begin
                r_state[l]    <= ST_RISING;
                r_rise_tgt[l] <= rise_cfg_i;
                r_rise_cnt[l] <= RiseW'(1);
              end
            end
            ST_RISING: begin
              // A push-pull driver overrides the remaining open-drain rise time.
              if (w_pp_high[l] || r_rise_cnt[l] == r_rise_tgt[l]) begin
                r_state[l] <= ST_HIGH;
              end else begin
                r_rise_cnt[l] <= r_rise_cnt[l] + RiseW'(1);
              end
            end
            default: r_state[l] <= ST_HIGH;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_contention <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_contention <= w_contention;
      if (clear_i) begin
        r_cnt <= CntW'(w_contention);
      end else if (w_contention && !(&r_cnt)) begin
        r_cnt <= r_cnt + CntW'(1);
      end
    end
  end

  assign sda_o            = (r_state[LineSda] == ST_HIGH);
  assign scl_o            = (r_state[LineScl] == ST_HIGH);
  assign contention_o     = r_contention;
  assign contention_cnt_o = r_cnt;

endmodule

// File: tb/tb_i3c_bus_harness_timed.sv
// Bench for i3c_bus_harness_timed: latency table, hand-written corner sequences,
// and a randomized run against a timestamp-based model of the bus rules.
module tb_i3c_bus_harness_timed;

  localparam int N   = 3;
  localparam int MD  = 15;
  localparam int DW  = 4;
  localparam int RW  = 8;
  localparam int CW  = 16;
  localparam int NR  = 1500;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  sda, scl, sel;
  logic [N*DW-1:0] dly;
  logic [RW-1:0] rise;
  logic          clr;
  logic          sda_o, scl_o, cont;
  logic [CW-1:0] cnt;

  i3c_bus_harness_timed #(
    .NumDevices(N), .MaxDelay(MD), .DelayW(DW), .RiseW(RW), .CntW(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .sda_i(sda), .scl_i(scl), .sel_od_pp_i(sel),
    .dly_cfg_i(dly), .rise_cfg_i(rise), .clear_i(clr),
    .sda_o(sda_o), .scl_o(scl_o), .contention_o(cont), .contention_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit is_scl;
    int dev;
    int dl0, dl1, dl2;
    bit pp;
    int rise_c;
    int len;
    int exp_fall;
    int exp_rise;
  } vec_t;

  vec_t vecs [6];

  // Model state for the randomized phase.
  logic [N-1:0] h_sda [NR];
  logic [N-1:0] h_scl [NR];
  int m_last_low [2];
  int m_rise_l1  [2];
  bit m_pp_seen  [2];
  bit exp_line   [2];
  bit exp_cont;
  int m_cnt;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sda = '1; scl = '1; clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // {is_scl, dev, dl0, dl1, dl2, pp, rise, len, first low cycle, first high cycle}
    vecs[0] = '{0, 1, 0, 5, 15, 0, 0,   10, 7,  17};
    vecs[1] = '{1, 0, 0, 0, 0,  0, 4,   5,  2,  11};
    vecs[2] = '{0, 2, 0, 0, 0,  1, 200, 4,  2,  6};
    vecs[3] = '{0, 2, 0, 0, 15, 0, 3,   2,  17, 22};
    vecs[4] = '{1, 1, 0, 7, 0,  1, 50,  1,  9,  10};
    vecs[5] = '{1, 2, 0, 0, 3,  0, 1,   3,  5,  9};

    sda = '1; scl = '1; sel = '0; dly = '0; rise = '0; clr = 1'b0; rst = 1'b0;
    #1 rst = 1'b1;

    // Reset state, during and after reset
    repeat (3) begin
      @(negedge clk);
      check("rst_sda", sda_o, 1);
      check("rst_scl", scl_o, 1);
      check("rst_cnt", cnt, 0);
      check("rst_cont", cont, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_sda", sda_o, 1);
      check("post_rst_scl", scl_o, 1);
      check("post_rst_cnt", cnt, 0);
    end

    // Latency table
    for (int v = 0; v < 6; v++) begin
      int fall, rs;
      bit obs;
      @(negedge clk);
      sda = '1; scl = '1; clr = 1'b0;
      sel  = vecs[v].pp ? (N'(1) << vecs[v].dev) : '0;
      dly  = {DW'(vecs[v].dl2), DW'(vecs[v].dl1), DW'(vecs[v].dl0)};
      rise = RW'(vecs[v].rise_c);
      repeat (20) @(negedge clk);
      fall = -1;
      rs   = -1;
      for (int i = 0; i < vecs[v].exp_rise + 6; i++) begin
        @(negedge clk);
        obs = vecs[v].is_scl ? scl_o : sda_o;
        if (fall < 0 && obs == 1'b0) fall = i;
        else if (fall >= 0 && rs < 0 && obs == 1'b1) rs = i;
        if (vecs[v].is_scl) scl[vecs[v].dev] = (i >= vecs[v].len);
        else                sda[vecs[v].dev] = (i >= vecs[v].len);
      end
      check($sformatf("vec%0d_fall", v), fall, vecs[v].exp_fall);
      check($sformatf("vec%0d_rise", v), rs, vecs[v].exp_rise);
    end

    // Open-drain rise interrupted by a re-pull: no glitch, later release completes
    @(negedge clk);
    sda = '1; scl = '1; sel = '0; dly = '0; rise = RW'(4);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      check("od_repull_scl", scl_o, (i < 2) || (i >= 18));
      scl[0] = !((i < 5) || (i >= 8 && i < 12));
    end

    // Contention: device 2 push-pull high, device 0 pulls SDA low for 3 cycles
    @(negedge clk);
    sel = 3'b100; rise = '0; dly = '0;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clr = 1'b0;
      check("cont_sda", sda_o, !(i >= 2 && i <= 4));
      check("cont_pulse", cont, (i >= 2 && i <= 4));
      check("cont_cnt", cnt, (i <= 1) ? 0 : ((i >= 4) ? 3 : i - 1));
      sda[0] = (i >= 3);
    end
    // Clear in the same cycle as a new event
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) check("clr_ev_before", cnt, 3);
      if (i == 2) check("clr_ev_pulse", cont, 1);
      if (i >= 2) check("clr_ev_cnt", cnt, 1);
      sda[0] = (i != 0);
      clr    = (i == 1);
    end
    clr = 1'b0;

    // Randomized run against the timestamp model
    sel = '0; dly = '0; rise = '0;
    do_reset();
    m_last_low = '{-1, -1};
    m_rise_l1  = '{0, 0};
    m_pp_seen  = '{0, 0};
    exp_line   = '{1, 1};
    exp_cont   = 1'b0;
    m_cnt      = 0;
    for (int c = 0; c < NR; c++) begin
      logic [N-1:0] ds, dc;
      bit any_low [2];
      bit pp_high [2];
      @(negedge clk);
      check("rnd_sda", sda_o, exp_line[0]);
      check("rnd_scl", scl_o, exp_line[1]);
      check("rnd_cont", cont, exp_cont);
      check("rnd_cnt", cnt, m_cnt);

      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 4) == 0) sda[k] = ~sda[k];
        if ($urandom_range(0, 5) == 0) scl[k] = ~scl[k];
      end
      if ($urandom_range(0, 39) == 0) sel = N'($urandom);
      if ($urandom_range(0, 29) == 0) dly = (N*DW)'($urandom);
      if ($urandom_range(0, 24) == 0) rise = RW'($urandom_range(0, 6));
      clr = ($urandom_range(0, 39) == 0);
      h_sda[c] = sda;
      h_scl[c] = scl;

      // Delayed value of device k is its input 1+d cycles ago (released before the run)
      for (int k = 0; k < N; k++) begin
        int d, idx;
        d = int'(dly[k*DW +: DW]);
        if (d > MD) d = MD;
        idx = c - 1 - d;
        ds[k] = (idx < 0) ? 1'b1 : h_sda[idx][k];
        dc[k] = (idx < 0) ? 1'b1 : h_scl[idx][k];
      end
      any_low[0] = (ds != '1);
      any_low[1] = (dc != '1);
      pp_high[0] = |(ds & sel);
      pp_high[1] = |(dc & sel);

      // A line is high once it has been free of lows for 1 cycle plus either the
      // rise time sampled on that first free cycle or any push-pull high seen since.
      for (int l = 0; l < 2; l++) begin
        if (any_low[l]) begin
          m_last_low[l] = c;
          m_pp_seen[l]  = 1'b0;
        end else if (m_last_low[l] >= 0 && c == m_last_low[l] + 1) begin
          m_rise_l1[l] = int'(rise);
          m_pp_seen[l] = pp_high[l];
        end else begin
          m_pp_seen[l] = m_pp_seen[l] | pp_high[l];
        end
        exp_line[l] = (m_last_low[l] < 0) ||
                      ((c + 1 >= m_last_low[l] + 2) &&
                       ((c + 1 >= m_last_low[l] + 2 + m_rise_l1[l]) || m_pp_seen[l]));
      end
      exp_cont = pp_high[0] && any_low[0];
      if (clr) m_cnt = int'(exp_cont);
      else if (exp_cont && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
    clr = 1'b0;

    // Counter saturation
    sel = 3'b100; dly = '0; rise = '0;
    do_reset();
    @(negedge clk);
    sda[0] = 1'b0;
    repeat (65535) @(negedge clk);
    check("sat_below_max", cnt, CMAX - 1);
    @(negedge clk);
    check("sat_at_max", cnt, CMAX);
    repeat (4465) @(negedge clk);
    check("sat_hold", cnt, CMAX);
    check("sat_pulse", cont, 1);
    check("sat_sda_low", sda_o, 0);

    // Reset during a long open-drain rise
    sel = '0; rise = RW'(200); sda = '1;
    repeat (10) @(negedge clk);
    check("mid_rise_sda_low", sda_o, 0);
    check("mid_rise_cnt", cnt, CMAX);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_rise_sda", sda_o, 1);
    check("rst_mid_rise_cnt", cnt, 0);
    check("rst_mid_rise_cont", cont, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("after_rst_sda", sda_o, 1);
      check("after_rst_scl", scl_o, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
